// File: rtl/four_bit_seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the final-iteration count.
package mult_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] LAST_ITER = 2'd3;

endpackage

// File: rtl/four_bit_seq_multiplier_adder.sv
// 4-bit ripple adder/subtractor; subtract inverts b and injects a carry-in,
// so the carry-out is the unsigned overflow bit for additions.
module four_bit_adder_subtractor (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       subtract,
    output logic [3:0] sum,
    output logic       carry
);

    logic [3:0] b_eff;
    logic [4:0] c;

    always_comb begin
        b_eff = b ^ {4{subtract}};
        c     = '0;
        c[0]  = subtract;
        sum   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b_eff[i] ^ c[i];
            c[i + 1] = (a[i] & b_eff[i]) | (a[i] & c[i]) | (b_eff[i] & c[i]);
        end
        carry = c[4];
    end

endmodule

// File: rtl/four_bit_seq_multiplier.sv
// Sequential 4x4 unsigned shift-and-add multiplier; one partial-product add
// per RUN cycle through the shared 4-bit adder, 8-bit product in {h,q}.
module four_bit_seq_multiplier
    import mult_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] Product,
    output logic       busy,
    output logic       done
);

    state_t     state;
    state_t     state_next;
    logic [3:0] m;
    logic [3:0] h;
    logic [3:0] q;
    logic [1:0] cnt;
    logic [3:0] addend;
    logic [3:0] sum;
    logic       carry;
    logic       load;
    logic       step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST_ITER) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
        load = (state == IDLE) && start;
        step = (state == RUN);
    end

    assign addend = m & {4{q[0]}};

    four_bit_adder_subtractor u_adder (
        .a        (h),
        .b        (addend),
        .subtract (1'b0),
        .sum      (sum),
        .carry    (carry)
    );

    // The carry-out becomes the new top bit of h, so 15*15 keeps its MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            m   <= '0;
            h   <= '0;
            q   <= '0;
            cnt <= '0;
        end else if (load) begin
            m   <= A;
            h   <= '0;
            q   <= B;
            cnt <= '0;
        end else if (step) begin
            h   <= {carry, sum[3:1]};
            q   <= {sum[0], q[3:1]};
            cnt <= cnt + 2'd1;
        end
    end

    assign Product = {h, q};

endmodule

// File: tb/tb_four_bit_seq_multiplier.sv
// Directed bench for four_bit_seq_multiplier with an expected-product queue
// checked on every done pulse.
module tb_four_bit_seq_multiplier;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] Product;
    logic       busy;
    logic       done;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned done_count = 0;
    logic [7:0]  sb[$];

    four_bit_seq_multiplier dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .A       (A),
        .B       (B),
        .Product (Product),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every done pulse must match the oldest outstanding expected product.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            if (sb.size() == 0) begin
                check("spurious_done", 8'd1, 8'd0);
            end else begin
                check("product_at_done", Product, sb.pop_front());
            end
        end
    end

    // Issue one multiply, track the adder carry against a local model each
    // RUN cycle, then confirm done timing and the post-done hold.
    task automatic do_mult(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] mh, mq, mm;
        logic [4:0] s5;
        logic [7:0] exp;
        exp = 8'(a) * 8'(b);
        A = a; B = b; start = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        start = 1'b0; A = '0; B = '0;
        check("busy_after_e0", 8'(busy), 8'd1);
        check("done_after_e0", 8'(done), 8'd0);
        mh = '0; mq = b; mm = a;
        for (int i = 0; i < 4; i++) begin
            s5 = 5'(mh) + 5'(mq[0] ? mm : 4'd0);
            check($sformatf("carry_iter%0d", i), 8'(dut.carry), 8'(s5[4]));
            mh = s5[4:1];
            mq = {s5[0], mq[3:1]};
            @(negedge clk);
        end
        check("done_after_e4", 8'(done), 8'd1);
        @(negedge clk);
        check("done_after_e5", 8'(done), 8'd0);
        check("busy_after_e5", 8'(busy), 8'd0);
        check("product_hold", Product, exp);
    endtask

    initial begin
        int unsigned dc;
        int unsigned busy_low;
        int          done_idx[$];
        reset = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        check("reset_product", Product, 8'h00);
        check("reset_busy", 8'(busy), 8'd0);
        check("reset_done", 8'(done), 8'd0);
        reset = 1'b0;
        @(negedge clk);

        do_mult(4'd13, 4'd11);
        do_mult(4'hF, 4'hF);
        do_mult(4'd0, 4'd9);
        do_mult(4'd9, 4'd0);
        do_mult(4'd1, 4'd9);
        check("product_15x15_const", 8'(4'hF) * 8'(4'hF), 8'hE1);

        // Second start during RUN must be ignored.
        dc = done_count;
        A = 4'd5; B = 4'd3; start = 1'b1;
        sb.push_back(8'h0F);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 4'd7; B = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = '0; B = '0;
        repeat (10) @(negedge clk);
        check("ignore_done_count", 8'(done_count - dc), 8'd1);
        check("ignore_m_unchanged", 8'(dut.m), 8'd5);
        check("ignore_product", Product, 8'h0F);

        // Reset mid-operation aborts without a done pulse.
        dc = done_count;
        A = 4'd6; B = 4'd6; start = 1'b1;
        sb.push_back(8'd36);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(sb.pop_back());
        check("abort_product", Product, 8'h00);
        check("abort_busy", 8'(busy), 8'd0);
        check("abort_done", 8'(done), 8'd0);
        repeat (8) @(negedge clk);
        check("abort_no_done", 8'(done_count - dc), 8'd0);

        // Continuous start: one result every 6 cycles, busy low one cycle between.
        A = 4'd2; B = 4'd3; start = 1'b1;
        repeat (3) sb.push_back(8'h06);
        busy_low = 0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (done === 1'b1) done_idx.push_back(k);
            if (busy === 1'b0) busy_low++;
        end
        start = 1'b0;
        check("hold_done_pulses", 8'(done_idx.size()), 8'd3);
        if (done_idx.size() == 3) begin
            check("hold_first_done", 8'(done_idx[0]), 8'd5);
            check("hold_period_1", 8'(done_idx[1] - done_idx[0]), 8'd6);
            check("hold_period_2", 8'(done_idx[2] - done_idx[1]), 8'd6);
        end
        check("hold_busy_low_cycles", 8'(busy_low), 8'd2);
        repeat (8) @(negedge clk);
        check("hold_idle_after", 8'(busy), 8'd0);
        check("scoreboard_drained", 8'(sb.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
